// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path: byte width, default oversampling
// and the receiver state encodings.
package uart_pkg;

    localparam int BYTE_W         = 8;
    localparam int OVERSAMPLE_DEF = 16;

    // Three bits leave spare encodings so a corrupted state register has a
    // defined way back to IDLE.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;

endpackage

// File: rtl/uart_rx_fifo.sv
// Received-byte buffer. A push is taken when there is room or when a pop frees
// a slot in the same cycle; a pop on an empty buffer is ignored. The head is
// forced to zero while empty so the consumer never sees stale data.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = BYTE_W
) (
    input  logic                     baud_clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          pop_ok;
    logic          push_ok;

    assign empty   = (count == '0);
    assign full    = (count == (PW + 1)'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign head    = empty ? '0 : mem[rd_ptr];

    // Storage array; contents are only meaningful below count, so no reset.
    always_ff @(posedge baud_clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge baud_clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (PW + 1)'(1);
                2'b01:   count <= count - (PW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Oversampling UART receiver: input synchronizer, programmable sample-tick
// generator, frame FSM and a small output FIFO.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   IDLE     | line idle, waiting for a low sample on a tick
//   START    | counting to mid start bit to confirm it is not a glitch
//   DATA     | sampling 8 data bits, LSB first, one per OVERSAMPLE ticks
//   STOP     | sampling the stop bit; push byte or flag framing error
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          baud_clk,
    input  logic                          reset,
    input  logic                          din,
    input  logic                          enable,
    input  logic [DIV_W-1:0]              div,
    output logic [BYTE_W-1:0]             rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          frame_err,
    output logic                          overrun,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int OS_W  = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(BYTE_W);
    localparam logic [OS_W-1:0]  OS_HALF  = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BYTE_W - 1);

    logic              din_s1;
    logic              din_s2;
    logic [DIV_W-1:0]  tick_cnt;
    logic              tick;

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [OS_W-1:0]   os_cnt;
    logic [OS_W-1:0]   os_nxt;
    logic [BIT_W-1:0]  bit_idx;
    logic [BIT_W-1:0]  bit_nxt;
    logic [BYTE_W-1:0] shreg;
    logic [BYTE_W-1:0] shreg_nxt;
    logic              push_req;
    logic              stop_bad;

    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;

    assign busy     = (state != ST_IDLE);
    assign rx_valid = !fifo_empty;
    assign pop      = rx_valid && rx_ready;
    assign tick     = enable && (tick_cnt == '0);

    // Two-flop synchronizer; resets to the idle-high line level.
    always_ff @(posedge baud_clk or negedge reset) begin
        if (!reset) begin
            din_s1 <= 1'b1;
            din_s2 <= 1'b1;
        end else begin
            din_s1 <= din;
            din_s2 <= din_s1;
        end
    end

    // Down-counting tick generator; reloads from the live div on each tick.
    always_ff @(posedge baud_clk or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
        end else if (!enable) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= div;
        end else begin
            tick_cnt <= tick_cnt - DIV_W'(1);
        end
    end

    // Frame FSM next-state, sampling and push/error decisions.
    always_comb begin
        state_nxt = state;
        os_nxt    = os_cnt;
        bit_nxt   = bit_idx;
        shreg_nxt = shreg;
        push_req  = 1'b0;
        stop_bad  = 1'b0;
        if (!enable || state > ST_STOP) begin
            state_nxt = ST_IDLE;
            os_nxt    = '0;
            bit_nxt   = '0;
        end else if (tick) begin
            case (state)
                ST_IDLE: begin
                    if (!din_s2) begin
                        state_nxt = ST_START;
                        os_nxt    = '0;
                    end
                end
                ST_START: begin
                    if (os_cnt == OS_HALF) begin
                        os_nxt = '0;
                        if (din_s2) begin
                            state_nxt = ST_IDLE;
                        end else begin
                            state_nxt = ST_DATA;
                            bit_nxt   = '0;
                        end
                    end else begin
                        os_nxt = os_cnt + OS_W'(1);
                    end
                end
                ST_DATA: begin
                    if (os_cnt == OS_LAST) begin
                        os_nxt    = '0;
                        shreg_nxt = {din_s2, shreg[BYTE_W-1:1]};
                        if (bit_idx == BIT_LAST) begin
                            state_nxt = ST_STOP;
                        end else begin
                            bit_nxt = bit_idx + BIT_W'(1);
                        end
                    end else begin
                        os_nxt = os_cnt + OS_W'(1);
                    end
                end
                ST_STOP: begin
                    if (os_cnt == OS_LAST) begin
                        os_nxt    = '0;
                        state_nxt = ST_IDLE;
                        push_req  = din_s2;
                        stop_bad  = !din_s2;
                    end else begin
                        os_nxt = os_cnt + OS_W'(1);
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    os_nxt    = '0;
                end
            endcase
        end
    end

    // FSM state, counters, shift register and the one-cycle status pulses.
    always_ff @(posedge baud_clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            os_cnt    <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_nxt;
            os_cnt    <= os_nxt;
            bit_idx   <= bit_nxt;
            shreg     <= shreg_nxt;
            frame_err <= stop_bad;
            overrun   <= push_req && fifo_full && !pop;
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (BYTE_W)
    ) u_fifo (
        .baud_clk  (baud_clk),
        .reset     (reset),
        .push      (push_req),
        .push_data (shreg),
        .pop       (pop),
        .head      (rx_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: stimulus pushes expected bytes, a monitor
// pops and compares on every accepted handshake and tracks status pulses.
module tb_uart_rx_ctrl;

    localparam int DIV_W      = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int OS         = 16;
    localparam int BIT_CLKS   = 64;

    logic             baud_clk = 1'b0;
    logic             reset    = 1'b1;
    logic             din      = 1'b1;
    logic             enable   = 1'b0;
    logic             rx_ready = 1'b0;
    logic [DIV_W-1:0] div      = 16'd3;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             frame_err;
    logic             overrun;
    logic             busy;
    logic [2:0]       fifo_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int en_cyc;
    int k_start;

    logic [7:0] exp_q [$];
    logic [7:0] mon_exp;
    int fe_pulses = 0, fe_run = 0, fe_width = 0;
    int ov_pulses = 0, ov_run = 0, ov_width = 0;

    uart_rx_ctrl #(
        .OVERSAMPLE (OS),
        .DIV_W      (DIV_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .baud_clk   (baud_clk),
        .reset      (reset),
        .din        (din),
        .enable     (enable),
        .div        (div),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 baud_clk = ~baud_clk;

    always @(posedge baud_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compares every accepted byte and measures status pulse widths.
    always @(negedge baud_clk) begin
        if (reset) begin
            if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_byte: got 0x%02h expected none", rx_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (rx_data !== mon_exp) begin
                        bad++;
                        $display("FAIL rx_data: got 0x%02h expected 0x%02h", rx_data, mon_exp);
                    end
                end
            end
            if (frame_err === 1'b1) fe_run++;
            else if (fe_run > 0) begin fe_pulses++; fe_width = fe_run; fe_run = 0; end
            if (overrun === 1'b1) ov_run++;
            else if (ov_run > 0) begin ov_pulses++; ov_width = ov_run; ov_run = 0; end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge baud_clk);
            #2;
        end
    endtask

    task automatic send_bit(input logic b);
        din = b;
        step(BIT_CLKS);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
        din = 1'b1;
    endtask

    task automatic wait_drain(input string name, input int bound);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            step(1);
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s: %0d bytes still pending, expected 0 within %0d cycles",
                     name, exp_q.size(), bound);
        end
    endtask

    initial begin
        #2 reset = 1'b0;
        #1;
        check("reset_rx_valid",   32'(rx_valid),   32'd0);
        check("reset_rx_data",    32'(rx_data),    32'd0);
        check("reset_frame_err",  32'(frame_err),  32'd0);
        check("reset_overrun",    32'(overrun),    32'd0);
        check("reset_busy",       32'(busy),       32'd0);
        check("reset_fifo_count", 32'(fifo_count), 32'd0);
        repeat (3) @(posedge baud_clk);
        #2 reset = 1'b1;
        step(2);
        enable = 1'b1;
        step(20);

        // Clean frame 0xA5, consumer always ready.
        rx_ready = 1'b1;
        fe_pulses = 0;
        ov_pulses = 0;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        step(20);
        wait_drain("drain_a5", 200);
        check("a5_frame_err_pulses", 32'(fe_pulses), 32'd0);

        // Three-tick low glitch must be rejected in START.
        din = 1'b0;
        step(12);
        din = 1'b1;
        step(200);
        check("glitch_busy",       32'(busy),       32'd0);
        check("glitch_rx_valid",   32'(rx_valid),   32'd0);
        check("glitch_fifo_count", 32'(fifo_count), 32'd0);
        check("glitch_fe_pulses",  32'(fe_pulses),  32'd0);

        // Bad stop bit: single-cycle frame_err, nothing queued.
        fe_pulses = 0;
        fe_width  = 0;
        send_frame(8'h3C, 1'b0);
        step(150);
        check("stop0_fe_pulses",  32'(fe_pulses),  32'd1);
        check("stop0_fe_width",   32'(fe_width),   32'd1);
        check("stop0_fifo_count", 32'(fifo_count), 32'd0);

        // Overrun on the fifth byte with the consumer stalled.
        rx_ready  = 1'b0;
        ov_pulses = 0;
        ov_width  = 0;
        for (int d = 1; d <= 4; d++) begin
            exp_q.push_back(8'(d));
            send_frame(8'(d), 1'b1);
            step(16);
        end
        check("ovr_before5_pulses", 32'(ov_pulses),  32'd0);
        check("ovr_before5_count",  32'(fifo_count), 32'd4);
        send_frame(8'h05, 1'b1);
        step(16);
        check("ovr_pulses",     32'(ov_pulses),  32'd1);
        check("ovr_width",      32'(ov_width),   32'd1);
        check("ovr_fifo_count", 32'(fifo_count), 32'd4);
        rx_ready = 1'b1;
        wait_drain("drain_ovr", 50);
        step(4);
        check("ovr_drained_count", 32'(fifo_count), 32'd0);

        // Reset in DATA bit 4 with two bytes queued.
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1);
        step(16);
        send_frame(8'h22, 1'b1);
        step(16);
        check("pre_reset_count", 32'(fifo_count), 32'd2);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        din = 1'b1;
        step(32);
        check("pre_reset_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        check("midreset_rx_valid",   32'(rx_valid),   32'd0);
        check("midreset_rx_data",    32'(rx_data),    32'd0);
        check("midreset_fifo_count", 32'(fifo_count), 32'd0);
        check("midreset_busy",       32'(busy),       32'd0);
        check("midreset_frame_err",  32'(frame_err),  32'd0);
        check("midreset_overrun",    32'(overrun),    32'd0);
        step(3);
        reset = 1'b1;
        step(BIT_CLKS);
        rx_ready = 1'b1;
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1);
        step(20);
        wait_drain("drain_7e", 200);

        // Dropping enable mid-frame aborts to IDLE with no flags.
        fe_pulses = 0;
        din = 1'b0;
        step(150);
        check("abort_busy_before", 32'(busy), 32'd1);
        enable = 1'b0;
        step(1);
        check("abort_busy_after", 32'(busy), 32'd0);
        din = 1'b1;
        step(BIT_CLKS);
        check("abort_fe_pulses",  32'(fe_pulses),  32'd0);
        check("abort_fifo_count", 32'(fifo_count), 32'd0);
        enable = 1'b1;
        en_cyc = cyc;
        step(20);

        // Full FIFO with a pop landing on the STOP sample cycle: no overrun.
        rx_ready  = 1'b0;
        ov_pulses = 0;
        for (int d = 1; d <= 4; d++) begin
            exp_q.push_back(8'(d * 16));
            send_frame(8'(d * 16), 1'b1);
            step(16);
        end
        check("full_count", 32'(fifo_count), 32'd4);
        // Align the start edge so the start bit is seen on the first tick;
        // the stop sample then lands 611 clocks after the start edge.
        while (((cyc - en_cyc - 2) % 4) != 0) step(1);
        k_start = cyc;
        exp_q.push_back(8'h50);
        fork
            send_frame(8'h50, 1'b1);
            begin
                while (cyc < k_start + 610) step(1);
                rx_ready = 1'b1;
                step(1);
                rx_ready = 1'b0;
            end
        join
        step(16);
        check("full_pop_ov_pulses",  32'(ov_pulses),  32'd0);
        check("full_pop_fifo_count", 32'(fifo_count), 32'd4);
        rx_ready = 1'b1;
        wait_drain("drain_full", 50);
        step(4);
        check("final_fifo_count", 32'(fifo_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16, meaning sample ticks per bit (even, >=4).
REQ-002 SHALL have parameter DIV_W, default 16, meaning width of baud divisor input.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning received-byte buffer entries (power of 2).
REQ-004 SHALL have port baud_clk  input  1  the single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port din  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port enable  input  1  receiver enable.
REQ-008 SHALL have port div  input  DIV_W  sample tick period minus one, in baud_clk cycles.
REQ-009 SHALL have port rx_data  output  8  head-of-FIFO byte.
REQ-010 SHALL have port rx_valid  output  1  FIFO non-empty.
REQ-011 SHALL have port rx_ready  input  1  consumer accept; pop when rx_valid && rx_ready.
REQ-012 SHALL have port frame_err  output  1  one-cycle pulse on bad stop bit.
REQ-013 SHALL have port overrun  output  1  one-cycle pulse on byte dropped because FIFO is full.
REQ-014 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-015 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  occupied entries.

Function
REQ-016 SHALL pass din through a 2-flop synchronizer (reset value 1); all decisions use the synchronized value.
REQ-017 SHALL assert a sample tick every div+1 cycles while enable is high; div=0 gives a tick every cycle; the tick counter reloads from the current div at each tick, so a div change takes effect after the tick in progress.
REQ-018 SHALL implement states IDLE, START, DATA, STOP; out-of-range state encodings go to IDLE.
REQ-019 IDLE: on a tick with synchronized din=0, go to START and clear the oversample counter.
REQ-020 START: on the tick where the count reaches OVERSAMPLE/2-1, sample; din=1 -> IDLE (glitch, no flags); din=0 -> DATA with bit index 0 and count cleared.
REQ-021 DATA: every OVERSAMPLE ticks, sample one bit into the shift register LSB-first; after bit 7 -> STOP.
REQ-022 STOP: after OVERSAMPLE ticks, sample; 1 -> push byte; 0 -> pulse frame_err, discard byte; either way -> IDLE on the same cycle.
REQ-023 SHALL accept a push when the FIFO is not full or a pop occurs in the same cycle; otherwise drop the byte and pulse overrun.
REQ-024 Push and pop in the same cycle SHALL leave fifo_count unchanged; pop on empty SHALL be ignored.
REQ-025 rx_data SHALL be stable while rx_valid=1 and rx_ready=0; bytes SHALL be delivered in arrival order.
REQ-026 enable low SHALL force IDLE on the next clock, abort any partial frame without flags, hold the tick counter cleared, and preserve FIFO contents and consumer handshake.
REQ-027 Latency SHALL be 1 cycle from the STOP-sample tick to rx_valid for an empty FIFO.

Reset
REQ-028 On reset low, asynchronously: state=IDLE, counters=0, shift register=0, synchronizer=1, FIFO empty, rx_valid=0, rx_data=0, frame_err=0, overrun=0, busy=0, fifo_count=0.
REQ-029 Reset mid-frame SHALL discard the partial byte and all FIFO contents; reception resumes only on a fresh start edge after release.

Structure
REQ-030 State encoding, OVERSAMPLE default and the byte width constant SHALL reside in a shared package uart_pkg.
REQ-031 The byte buffer SHALL be a separate sub-module uart_rx_fifo (push/pop/full/empty/count); tick generator and FSM stay in uart_rx_ctrl.

Verification
REQ-032 div=3, OVERSAMPLE=16 (64 clocks/bit), send 0xA5 with stop=1 -> rx_valid rises with rx_data=0xA5; frame_err=0.
REQ-033 Low pulse on din of 3 sample ticks (12 clocks) -> START rejects, back in IDLE, no rx_valid, no flags.
REQ-034 Send 0x3C with stop=0 -> frame_err pulses exactly 1 cycle; fifo_count stays 0.
REQ-035 rx_ready=0, send 0x01..0x05 -> overrun pulses once, on byte 5; fifo_count=4; then reading yields 0x01,0x02,0x03,0x04.
REQ-036 Assert reset during DATA bit 4 with 2 bytes queued -> all outputs at reset values immediately; next full frame 0x7E received correctly.
REQ-037 FIFO full with rx_ready=1 held while the next frame's STOP tick lands -> no overrun, fifo_count stays 4, order preserved.
